// File: rtl/pa_hpcp_cnt_ovf.sv
// rtl/pa_hpcp_cnt_ovf.sv - PMU hardware performance counter with sticky overflow and interrupt pulse
//
// Purpose:
//   One programmable HPM counter. Per-cycle event increments are registered
//   once (inc_q) and then added into a CNT_WIDTH-bit counter. A carry out of
//   the top bit sets a sticky overflow flag and, when enabled, produces a
//   one-cycle interrupt pulse. Software can overwrite the low or high half.
//   All state runs on a locally gated copy of forever_cpuclk.
//
// Ports:
//   forever_cpuclk      in   ungated CPU clock
//   cpurst_b            in   asynchronous active-low reset
//   cp0_hpcp_icg_en     in   module enable of the clock gate (1 = clock always on)
//   pad_yy_icg_scan_en  in   scan enable, forces the gated clock on
//   cnt_en              in   counting allowed this cycle
//   evt_inc             in   number of events this cycle
//   cnt_wen             in   write hpcp_wdata into the low half
//   cnt_hwen            in   write hpcp_wdata (low bits) into the high half
//   hpcp_wdata          in   CSR write data
//   ovf_clr             in   clear the sticky overflow flag
//   ovf_int_en          in   overflow interrupt enable
//   cnt_output          out  current counter value (flop)
//   cnt_ovf             out  sticky overflow flag (flop)
//   cnt_ovf_int         out  one-cycle overflow interrupt pulse (flop)

module pa_hpcp_cnt_ovf #(
  parameter int CNT_WIDTH   = 64,
  parameter int WDATA_WIDTH = 32,
  parameter int INC_WIDTH   = 3
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic                   cp0_hpcp_icg_en,
  input  logic                   pad_yy_icg_scan_en,
  input  logic                   cnt_en,
  input  logic [INC_WIDTH-1:0]   evt_inc,
  input  logic                   cnt_wen,
  input  logic                   cnt_hwen,
  input  logic [WDATA_WIDTH-1:0] hpcp_wdata,
  input  logic                   ovf_clr,
  input  logic                   ovf_int_en,
  output logic [CNT_WIDTH-1:0]   cnt_output,
  output logic                   cnt_ovf,
  output logic                   cnt_ovf_int
);

  localparam int HI_WIDTH = CNT_WIDTH - WDATA_WIDTH;

  logic                 hpcp_clk;
  logic                 local_en;

  logic [INC_WIDTH-1:0] inc_q, inc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_int_q, ovf_int_d;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic                 ovf_evt;

  // Every state change is covered by local_en, so gating with module_en=0
  // is functionally invisible. cnt_ovf_int is included so the pulse can
  // fall back to 0 on the following edge.
  assign local_en = cnt_wen | cnt_hwen | ovf_clr | ovf_int_q
                  | (evt_inc != '0) | (inc_q != '0);

  gated_clk_cell x_hpcp_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (cp0_hpcp_icg_en),
    .local_en           (local_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (hpcp_clk)
  );

  // One extra bit captures the carry out of the counter.
  assign cnt_sum = {1'b0, cnt_q} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_q};

  always_comb begin
    cnt_d   = cnt_q;
    ovf_evt = 1'b0;
    if (cnt_wen) begin
      cnt_d = {cnt_q[CNT_WIDTH-1:WDATA_WIDTH], hpcp_wdata};
    end else if (cnt_hwen) begin
      cnt_d = {hpcp_wdata[HI_WIDTH-1:0], cnt_q[WDATA_WIDTH-1:0]};
    end else if (cnt_en && (inc_q != '0)) begin
      cnt_d   = cnt_sum[CNT_WIDTH-1:0];
      ovf_evt = cnt_sum[CNT_WIDTH];
    end
  end

  assign inc_d     = cnt_en ? evt_inc : '0;
  // Set has priority over clear.
  assign ovf_d     = ovf_evt | (ovf_q & ~ovf_clr);
  assign ovf_int_d = ovf_evt & ovf_int_en;

  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      inc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_int_q <= 1'b0;
    end else begin
      inc_q     <= inc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ovf_int_q <= ovf_int_d;
    end
  end

  assign cnt_output  = cnt_q;
  assign cnt_ovf     = ovf_q;
  assign cnt_ovf_int = ovf_int_q;

endmodule

// Latch-based integrated clock gate. The enable is captured while clk_in is
// low so clk_out cannot glitch during the high phase.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch;
  logic clk_en_lat;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  always_latch begin
    if (!clk_in) begin
      clk_en_lat = clk_en_bf_latch | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & clk_en_lat;

endmodule

// File: tb/tb_pa_hpcp_cnt_ovf.sv
// tb/tb_pa_hpcp_cnt_ovf.sv - directed self-checking bench for pa_hpcp_cnt_ovf

module tb_pa_hpcp_cnt_ovf;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Default instance: 64/32/3
  logic        rst_n, icg_en, cnt_en, cnt_wen, cnt_hwen, ovf_clr, ovf_int_en;
  logic [2:0]  evt_inc;
  logic [31:0] wdata;
  logic [63:0] cnt;
  logic        ovf, ovf_int;

  // Swept instance: 40/32/1
  logic        rst2_n, cnt_en2, cnt_wen2, cnt_hwen2, ovf_clr2, ovf_int_en2;
  logic [0:0]  evt_inc2;
  logic [31:0] wdata2;
  logic [39:0] cnt2;
  logic        ovf2, ovf_int2;

  pa_hpcp_cnt_ovf #(.CNT_WIDTH(64), .WDATA_WIDTH(32), .INC_WIDTH(3)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .cp0_hpcp_icg_en    (icg_en),
    .pad_yy_icg_scan_en (1'b0),
    .cnt_en             (cnt_en),
    .evt_inc            (evt_inc),
    .cnt_wen            (cnt_wen),
    .cnt_hwen           (cnt_hwen),
    .hpcp_wdata         (wdata),
    .ovf_clr            (ovf_clr),
    .ovf_int_en         (ovf_int_en),
    .cnt_output         (cnt),
    .cnt_ovf            (ovf),
    .cnt_ovf_int        (ovf_int)
  );

  pa_hpcp_cnt_ovf #(.CNT_WIDTH(40), .WDATA_WIDTH(32), .INC_WIDTH(1)) dut2 (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst2_n),
    .cp0_hpcp_icg_en    (1'b1),
    .pad_yy_icg_scan_en (1'b0),
    .cnt_en             (cnt_en2),
    .evt_inc            (evt_inc2),
    .cnt_wen            (cnt_wen2),
    .cnt_hwen           (cnt_hwen2),
    .hpcp_wdata         (wdata2),
    .ovf_clr            (ovf_clr2),
    .ovf_int_en         (ovf_int_en2),
    .cnt_output         (cnt2),
    .cnt_ovf            (ovf2),
    .cnt_ovf_int        (ovf_int2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs are driven and outputs sampled on the falling edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 0; icg_en = 0; cnt_en = 0; cnt_wen = 0; cnt_hwen = 0;
    ovf_clr = 0; ovf_int_en = 0; evt_inc = 0; wdata = 0;
    rst2_n = 0; cnt_en2 = 0; cnt_wen2 = 0; cnt_hwen2 = 0;
    ovf_clr2 = 0; ovf_int_en2 = 0; evt_inc2 = 0; wdata2 = 0;
    step(2);
    chk("rst_cnt", cnt, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_int", {63'd0, ovf_int}, 64'd0);
    rst_n = 1; rst2_n = 1;
    step(1);

    // Single events: first increment lands two edges after evt_inc is presented
    cnt_en = 1; evt_inc = 3'd1;
    step(1);
    chk("lat_edge1", cnt, 64'd0);
    step(1);
    chk("lat_edge2", cnt, 64'd1);
    step(8);
    evt_inc = 3'd0;
    step(2);
    chk("count10", cnt, 64'd10);
    chk("count10_ovf", {63'd0, ovf}, 64'd0);

    // Multi-event increments
    cnt_wen = 1; wdata = 32'd0; step(1); cnt_wen = 0;
    evt_inc = 3'd7; step(4);
    evt_inc = 3'd0; step(2);
    chk("multi28", cnt, 64'd28);

    // Pending increment dropped when cnt_en falls
    cnt_wen = 1; wdata = 32'd0; step(1); cnt_wen = 0;
    evt_inc = 3'd7; step(4);
    evt_inc = 3'd0; cnt_en = 0; step(1);
    cnt_en = 1; step(1);
    chk("drop21", cnt, 64'd21);

    // Half writes, with the clock gate forced open to show equivalence
    icg_en = 1;
    cnt_wen = 1; wdata = 32'hFFFF_FFFF; step(1);
    cnt_wen = 0; cnt_hwen = 1; step(1); cnt_hwen = 0;
    chk("half_all1", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("half_ovf", {63'd0, ovf}, 64'd0);
    cnt_wen = 1; cnt_hwen = 1; wdata = 32'h5; step(1);
    cnt_wen = 0; cnt_hwen = 0;
    chk("wen_hwen", cnt, 64'hFFFF_FFFF_0000_0005);
    icg_en = 0;

    // Overflow with interrupt enabled
    cnt_wen = 1; wdata = 32'hFFFF_FFFE; step(1); cnt_wen = 0;
    ovf_int_en = 1; evt_inc = 3'd3; step(1);
    evt_inc = 3'd0; step(1);
    chk("ovf_cnt", cnt, 64'd1);
    chk("ovf_flag", {63'd0, ovf}, 64'd1);
    chk("ovf_pulse", {63'd0, ovf_int}, 64'd1);
    step(1);
    chk("ovf_pulse_end", {63'd0, ovf_int}, 64'd0);
    chk("ovf_sticky", {63'd0, ovf}, 64'd1);

    // Overflow with interrupt disabled
    ovf_clr = 1; step(1); ovf_clr = 0;
    chk("clr", {63'd0, ovf}, 64'd0);
    cnt_hwen = 1; wdata = 32'hFFFF_FFFF; step(1); cnt_hwen = 0;
    cnt_wen = 1; wdata = 32'hFFFF_FFFE; step(1); cnt_wen = 0;
    ovf_int_en = 0; evt_inc = 3'd3; step(1);
    evt_inc = 3'd0; step(1);
    chk("noint_cnt", cnt, 64'd1);
    chk("noint_flag", {63'd0, ovf}, 64'd1);
    chk("noint_pulse", {63'd0, ovf_int}, 64'd0);
    step(1);
    chk("noint_pulse2", {63'd0, ovf_int}, 64'd0);

    // Overflow in the same cycle as ovf_clr: set wins
    ovf_clr = 1; step(1); ovf_clr = 0;
    cnt_hwen = 1; wdata = 32'hFFFF_FFFF; step(1); cnt_hwen = 0;
    cnt_wen = 1; wdata = 32'hFFFF_FFFE; step(1); cnt_wen = 0;
    evt_inc = 3'd3; step(1);
    evt_inc = 3'd0; ovf_clr = 1; step(1); ovf_clr = 0;
    chk("set_wins", {63'd0, ovf}, 64'd1);
    ovf_clr = 1; step(1); ovf_clr = 0;
    chk("clr_alone", {63'd0, ovf}, 64'd0);

    // Write collides with pending inc_q=2
    evt_inc = 3'd2; step(1);
    evt_inc = 3'd0; cnt_wen = 1; wdata = 32'h100; step(1); cnt_wen = 0;
    step(1);
    chk("wr_collide", cnt, 64'h100);

    // Repeated overflow while the flag is already set still pulses
    ovf_int_en = 1;
    cnt_hwen = 1; wdata = 32'hFFFF_FFFF; step(1); cnt_hwen = 0;
    cnt_wen = 1; step(1); cnt_wen = 0;
    evt_inc = 3'd1; step(1); evt_inc = 3'd0; step(1);
    chk("rep1_pulse", {63'd0, ovf_int}, 64'd1);
    cnt_wen = 1; step(1); cnt_wen = 0;
    cnt_hwen = 1; step(1); cnt_hwen = 0;
    chk("rep2_pre_flag", {63'd0, ovf}, 64'd1);
    evt_inc = 3'd1; step(1); evt_inc = 3'd0; step(1);
    chk("rep2_cnt", cnt, 64'd0);
    chk("rep2_pulse", {63'd0, ovf_int}, 64'd1);

    // Parameter sweep 40/32/1
    cnt_hwen2 = 1; wdata2 = 32'h0000_ABCD; step(1); cnt_hwen2 = 0;
    chk("w40_hwen", {24'd0, cnt2}, 64'h00CD_0000_0000);
    cnt_wen2 = 1; wdata2 = 32'hFFFF_FFFF; step(1); cnt_wen2 = 0;
    cnt_hwen2 = 1; wdata2 = 32'h0000_00FF; step(1); cnt_hwen2 = 0;
    chk("w40_max", {24'd0, cnt2}, 64'hFF_FFFF_FFFF);
    cnt_en2 = 1; ovf_int_en2 = 1; evt_inc2 = 1'b1; step(1);
    evt_inc2 = 1'b0; step(1);
    chk("w40_wrap", {24'd0, cnt2}, 64'd0);
    chk("w40_ovf", {63'd0, ovf2}, 64'd1);
    chk("w40_int", {63'd0, ovf_int2}, 64'd1);
    evt_inc2 = 1'b1; step(3);
    chk("w40_count", {24'd0, cnt2}, 64'd2);
    #2 rst2_n = 0;
    #1;
    chk("w40_arst_cnt", {24'd0, cnt2}, 64'd0);
    chk("w40_arst_ovf", {63'd0, ovf2}, 64'd0);
    chk("w40_arst_int", {63'd0, ovf_int2}, 64'd0);
    evt_inc2 = 1'b0;
    step(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
